spi_word_slave: RTL and testbench
=================================

# spi_word_slave

Oversampling SPI slave front end that sits directly upstream of the SRAM-like SPI interface. It synchronises the raw SPI pins into the system clock, deserialises MOSI into 16-bit address and data words, and serialises the read word back on MISO. Each completed word goes out as a single-cycle strobe, so the downstream interface only ever sees clean, clk-domain word events.

## Interface
- `WORD_W`, 16, bits per SPI word (address and data)
- `SYNC_STAGES`, 2, flip-flop stages on `spi_scl`, `spi_sdi`, `spi_cs_addr`, `spi_cs_data` (min 2)
- `clk` in 1: system clock; all logic is single-clock
- `rst` in 1: synchronous, active-high reset
- `spi_scl` in 1: SPI clock, mode 0 (CPOL=0, CPHA=0), MSB first
- `spi_sdi` in 1: MOSI
- `spi_sdo` out 1: MISO
- `spi_cs_addr` in 1: active-low chip select, address frame
- `spi_cs_data` in 1: active-low chip select, data frame
- `addr_valid` out 1: one-cycle pulse, address word complete
- `addr` out WORD_W: last received address, held until the next `addr_valid`
- `wr_valid` out 1: one-cycle pulse, data word complete
- `wr_data` out WORD_W: last received data word, held
- `rd_req` out 1: one-cycle pulse, requests the next TX word
- `tx_data` in WORD_W: TX word, must be valid exactly 1 cycle after `rd_req`
- `frame_err` out 1: one-cycle pulse on an aborted or illegal frame
- `err_cnt` out 8: aborted-frame counter (see Configuration)

## Operation
- Synchronised inputs are `scl_s`, `sdi_s`, `csa_s`, `csd_s`.
- Edge detect on `scl_s`:
  - rise = prev 0, now 1
  - fall = prev 1, now 0
- FSM states IDLE, ADDR, DATA_LD, DATA, ERR.
- IDLE:
  - `csa_s`=0 and `csd_s`=1 → ADDR; bit counter cleared.
  - `csd_s`=0 and `csa_s`=1 → DATA_LD; `rd_req` pulses.
  - Both low → ERR; `frame_err` pulses.
- ADDR:
  - On each rise, shift `sdi_s` into the shift register LSB and increment the bit counter.
  - After bit WORD_W: `addr` ← shift register, `addr_valid` pulses, counter → 0, stay in ADDR (a back-to-back burst overwrites `addr`).
- DATA_LD (1 cycle): TX shift register ← `tx_data`, `spi_sdo` ← `tx_data[WORD_W-1]`, then → DATA.
- DATA:
  - Rise: shift in `sdi_s`, as in ADDR.
  - Fall: shift TX register left; `spi_sdo` ← new MSB.
  - After bit WORD_W: `wr_data` ← RX shift register, `wr_valid` pulses, `rd_req` pulses, → DATA_LD for the next burst word.
- Either state, own CS returns high:
  - Counter = 0: → IDLE silently.
  - Counter ≠ 0: partial word is discarded (no strobe), `frame_err` pulses, → IDLE.
- Either state, other CS goes low → ERR with `frame_err`.
- ERR: `spi_sdo`=0, no strobes; → IDLE only when both CS are high.
- `spi_sdo` is 0 in IDLE, ADDR and ERR.
- Bit counter width is clog2(WORD_W)+1; it never wraps past WORD_W.

## Timing
- Reset values: all outputs 0, FSM IDLE, shift registers, `addr`, `wr_data` and `err_cnt` all 0, synchroniser flops 1 for CS and 0 for SCL/SDI.
- Input latency is SYNC_STAGES+1 clk from pin to edge detect.
- `addr_valid`/`wr_valid` assert SYNC_STAGES+1 clk after the WORD_W-th SCL rising edge.
- Host constraints:
  - SCL high and low phases each ≥ SYNC_STAGES+3 clk.
  - CS fall to first SCL rise ≥ SYNC_STAGES+4 clk.
  - Last SCL fall to CS rise ≥ SYNC_STAGES+2 clk.
  - Violations are out of scope.
- `rd_req` is followed by `tx_data` capture on the next cycle in DATA_LD; the downstream side must not stall.
- `rst` asserted mid-frame returns the block to IDLE on the next edge, with no strobes; a frame still in progress after reset is treated as a fresh frame from CS low only.

## Configuration
- `SPI_ERR_CNT_EN` defined:
  - `err_cnt` increments on every `frame_err` pulse.
  - Saturates at 255.
  - Cleared only by `rst`.
- Undefined: `err_cnt` is tied to 0 and no counter flops are inferred; `frame_err` is unaffected.

## Test plan
- Address frame: CS_addr low, shift 0x00A5, CS high → one `addr_valid`, `addr`=0x00A5, no `wr_valid`, no `frame_err`.
- Data burst: CS_data low, `tx_data` answers the first `rd_req` with 0x1234 and the second with 0xBEEF, host shifts 0xCAFE then 0x0F0F → MISO carries 0x1234 then 0xBEEF; `wr_data` = 0xCAFE then 0x0F0F; 3 `rd_req`, 2 `wr_valid`.
- Partial word: CS_data low, 9 SCL cycles, CS high → no `wr_valid`, one `frame_err`, IDLE, `spi_sdo`=0.
- Both CS low simultaneously, 16 clocks of SCL → ERR, no strobes, one `frame_err`; releasing both CS then an address frame 0x0003 → normal `addr_valid`.
- `rst` asserted after 8 bits of a data word → all outputs 0 next cycle; `err_cnt` 0; the remaining 8 bits produce no strobe.
- With `SPI_ERR_CNT_EN`: 300 aborted frames → `err_cnt`=255; without the macro → `err_cnt`=0 throughout.

Source files
------------

// File: rtl/spi_word_slave.sv
// Oversampling SPI (mode 0, MSB first) slave front end: synchronises the pins, deserialises
// address/data words into clk-domain strobes and serialises TX words. Optional SPI_ERR_CNT_EN.
module spi_word_slave #(
  parameter int WORD_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_scl,
  input  logic              spi_sdi,
  output logic              spi_sdo,
  input  logic              spi_cs_addr,
  input  logic              spi_cs_data,
  output logic              addr_valid,
  output logic [WORD_W-1:0] addr,
  output logic              wr_valid,
  output logic [WORD_W-1:0] wr_data,
  output logic              rd_req,
  input  logic [WORD_W-1:0] tx_data,
  output logic              frame_err,
  output logic [7:0]        err_cnt
);

  localparam int CNT_W = $clog2(WORD_W) + 1;

  typedef enum logic [2:0] {IDLE, ADDR, DATA_LD, DATA, ERR} state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  scl_sync, sdi_sync, csa_sync, csd_sync;
  logic                    scl_s, sdi_s, csa_s, csd_s, scl_prev;
  logic                    rise, fall;
  logic [CNT_W-1:0]        bit_cnt;
  logic [WORD_W-2:0]       rx_sr;
  logic [WORD_W-2:0]       tx_sr;
  logic [WORD_W-1:0]       rx_next;
  logic                    word_done;

  // Idle pins reset to their inactive levels so reset never fakes a CS edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '0;
      sdi_sync <= '0;
      csa_sync <= '1;
      csd_sync <= '1;
      scl_prev <= 1'b0;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], spi_scl};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi};
      csa_sync <= {csa_sync[SYNC_STAGES-2:0], spi_cs_addr};
      csd_sync <= {csd_sync[SYNC_STAGES-2:0], spi_cs_data};
      scl_prev <= scl_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync[SYNC_STAGES-1];
  assign csa_s     = csa_sync[SYNC_STAGES-1];
  assign csd_s     = csd_sync[SYNC_STAGES-1];
  assign rise      = scl_s & ~scl_prev;
  assign fall      = ~scl_s & scl_prev;
  assign rx_next   = {rx_sr, sdi_s};
  assign word_done = (bit_cnt == CNT_W'(WORD_W - 1));

  // NOTE: every register here is assigned with <= so all branches see the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      rx_sr      <= '0;
      tx_sr      <= '0;
      addr       <= '0;
      wr_data    <= '0;
      addr_valid <= 1'b0;
      wr_valid   <= 1'b0;
      rd_req     <= 1'b0;
      frame_err  <= 1'b0;
      spi_sdo    <= 1'b0;
    end else begin
      addr_valid <= 1'b0;
      wr_valid   <= 1'b0;
      rd_req     <= 1'b0;
      frame_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          spi_sdo <= 1'b0;
          bit_cnt <= '0;
          if (!csa_s && !csd_s) begin
            state     <= ERR;
            frame_err <= 1'b1;
          end else if (!csa_s) begin
            state <= ADDR;
          end else if (!csd_s) begin
            state  <= DATA_LD;
            rd_req <= 1'b1;
          end
        end
        ADDR: begin
          spi_sdo <= 1'b0;
          if (!csd_s) begin
            state     <= ERR;
            frame_err <= 1'b1;
          end else if (csa_s) begin
            state     <= IDLE;
            frame_err <= (bit_cnt != '0);
          end else if (rise) begin
            rx_sr <= rx_next[WORD_W-2:0];
            if (word_done) begin
              addr       <= rx_next;
              addr_valid <= 1'b1;
              bit_cnt    <= '0;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        DATA_LD: begin
          tx_sr   <= tx_data[WORD_W-2:0];
          spi_sdo <= tx_data[WORD_W-1];
          state   <= DATA;
        end
        DATA: begin
          if (!csa_s) begin
            state     <= ERR;
            frame_err <= 1'b1;
            spi_sdo   <= 1'b0;
          end else if (csd_s) begin
            state     <= IDLE;
            frame_err <= (bit_cnt != '0);
            spi_sdo   <= 1'b0;
          end else if (rise) begin
            rx_sr <= rx_next[WORD_W-2:0];
            if (word_done) begin
              wr_data  <= rx_next;
              wr_valid <= 1'b1;
              rd_req   <= 1'b1;
              bit_cnt  <= '0;
              state    <= DATA_LD;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end else if (fall && bit_cnt != '0) begin
            // The fall closing a word must not shift out the freshly loaded next MSB.
            spi_sdo <= tx_sr[WORD_W-2];
            tx_sr   <= {tx_sr[WORD_W-3:0], 1'b0};
          end
        end
        ERR: begin
          spi_sdo <= 1'b0;
          if (csa_s && csd_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (frame_err && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_spi_word_slave.sv
// Directed bench for spi_word_slave: host-side pin driver, registered-style TX responder and a
// word-level scoreboard checked every cycle, plus literal spot checks.
module tb_spi_word_slave;
  localparam int W  = 16;
  localparam int SS = 2;
  localparam int H  = 6;  // SCL half period in clk cycles

  logic         clk = 1'b0, rst = 1'b1;
  logic         spi_scl = 1'b0, spi_sdi = 1'b0, spi_cs_addr = 1'b1, spi_cs_data = 1'b1;
  logic         spi_sdo, addr_valid, wr_valid, rd_req, frame_err;
  logic [W-1:0] addr, wr_data;
  logic [W-1:0] tx_data = '0;
  logic [7:0]   err_cnt;

  always #5 clk = ~clk;

  spi_word_slave #(.WORD_W(W), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .spi_scl(spi_scl), .spi_sdi(spi_sdi), .spi_sdo(spi_sdo),
    .spi_cs_addr(spi_cs_addr), .spi_cs_data(spi_cs_data), .addr_valid(addr_valid),
    .addr(addr), .wr_valid(wr_valid), .wr_data(wr_data), .rd_req(rd_req),
    .tx_data(tx_data), .frame_err(frame_err), .err_cnt(err_cnt)
  );

  int n_checks = 0, n_errors = 0;
  int cyc = 0, last_rise = 0;
  int act_rd = 0, act_fe = 0, exp_rd = 0, exp_fe = 0, fe_since_rst = 0;
  bit mon_en = 1'b0, sdo_zero = 1'b1;
  logic [W-1:0] exp_addr_q[$], exp_wr_q[$], tx_q[$];
  logic [W-1:0] model_addr = '0, model_wr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream side: answers each rd_req with the next queued word and holds it.
  always @(negedge clk) begin
    if (rd_req) begin
      if (tx_q.size() != 0) tx_data = tx_q.pop_front();
      else tx_data = '0;
    end
  end

  // Word-level scoreboard, evaluated every cycle away from the active edge.
  always @(negedge clk) begin
    if (!mon_en) begin
      model_addr = '0;
      model_wr   = '0;
    end else begin
      if (addr_valid) begin
        check("addr_valid_expected", 32'(exp_addr_q.size() != 0), 1);
        if (exp_addr_q.size() != 0) begin
          model_addr = exp_addr_q.pop_front();
          check("addr_valid_latency", cyc, last_rise + SS + 1);
        end
      end
      if (wr_valid) begin
        check("wr_valid_expected", 32'(exp_wr_q.size() != 0), 1);
        if (exp_wr_q.size() != 0) begin
          model_wr = exp_wr_q.pop_front();
          check("wr_valid_latency", cyc, last_rise + SS + 1);
        end
      end
      check("addr_value", addr, model_addr);
      check("wr_data_value", wr_data, model_wr);
      if (rd_req) act_rd++;
      if (frame_err) act_fe++;
      if (sdo_zero) check("sdo_idle_zero", spi_sdo, 0);
`ifndef SPI_ERR_CNT_EN
      check("err_cnt_tied_zero", err_cnt, 0);
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input bit chk, input logic exp_b);
    spi_sdi = b;
    tick(H);
    if (chk) check("miso_bit", spi_sdo, exp_b);
    spi_scl   = 1'b1;
    last_rise = cyc;
    tick(H);
    spi_scl = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit chk, input logic [W-1:0] tx);
    for (int i = W - 1; i >= 0; i--) send_bit(w[i], chk, tx[i]);
  endtask

  task automatic addr_frame(input logic [W-1:0] w);
    spi_cs_addr = 1'b0;
    tick(2);
    exp_addr_q.push_back(w);
    send_word(w, 1'b0, '0);
    tick(6);
    spi_cs_addr = 1'b1;
    tick(8);
  endtask

  task automatic end_checks(input string tag);
    int exp_cnt;
`ifdef SPI_ERR_CNT_EN
    exp_cnt = (fe_since_rst > 255) ? 255 : fe_since_rst;
`else
    exp_cnt = 0;
`endif
    check({tag, "_rd_req_count"}, act_rd, exp_rd);
    check({tag, "_frame_err_count"}, act_fe, exp_fe);
    check({tag, "_addr_words_left"}, exp_addr_q.size(), 0);
    check({tag, "_wr_words_left"}, exp_wr_q.size(), 0);
    check({tag, "_err_cnt"}, err_cnt, exp_cnt);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr_valid"}, addr_valid, 0);
    check({tag, "_addr"}, addr, 0);
    check({tag, "_wr_valid"}, wr_valid, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_rd_req"}, rd_req, 0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
    check({tag, "_spi_sdo"}, spi_sdo, 0);
  endtask

  initial begin
    logic [W-1:0] pat;

    tick(3);
    check_all_zero("reset");
    rst = 1'b0;
    tick(2);
    mon_en = 1'b1;

    // Single address word
    addr_frame(16'h00A5);
    end_checks("addr_frame");
    check("addr_literal_00a5", addr, 16'h00A5);

    // Back-to-back address burst in one frame overwrites addr
    spi_cs_addr = 1'b0;
    tick(2);
    exp_addr_q.push_back(16'h1357);
    exp_addr_q.push_back(16'h2468);
    send_word(16'h1357, 1'b0, '0);
    send_word(16'h2468, 1'b0, '0);
    tick(6);
    spi_cs_addr = 1'b1;
    tick(8);
    end_checks("addr_burst");
    check("addr_literal_2468", addr, 16'h2468);

    // Two-word data burst with MISO readback
    tx_q.push_back(16'h1234);
    tx_q.push_back(16'hBEEF);
    exp_wr_q.push_back(16'hCAFE);
    exp_wr_q.push_back(16'h0F0F);
    exp_rd += 3;
    sdo_zero    = 1'b0;
    spi_cs_data = 1'b0;
    tick(2);
    send_word(16'hCAFE, 1'b1, 16'h1234);
    send_word(16'h0F0F, 1'b1, 16'hBEEF);
    tick(6);
    spi_cs_data = 1'b1;
    tick(4);
    sdo_zero = 1'b1;
    tick(4);
    end_checks("data_burst");
    check("wr_data_literal_0f0f", wr_data, 16'h0F0F);

    // Partial data word: 9 bits then CS high
    tx_q.push_back(16'h8001);
    exp_rd += 1;
    exp_fe += 1;
    fe_since_rst += 1;
    pat = 16'hB3C5;
    sdo_zero    = 1'b0;
    spi_cs_data = 1'b0;
    tick(2);
    for (int i = W - 1; i >= W - 9; i--) send_bit(pat[i], 1'b1, 16'h8001 >> i);
    tick(6);
    spi_cs_data = 1'b1;
    tick(4);
    sdo_zero = 1'b1;
    check("partial_sdo_zero", spi_sdo, 0);
    tick(4);
    end_checks("partial_word");

    // Data CS dropping during an address frame
    exp_fe += 1;
    fe_since_rst += 1;
    spi_cs_addr = 1'b0;
    tick(2);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 1'b0);
    spi_cs_data = 1'b0;
    tick(6);
    spi_cs_addr = 1'b1;
    spi_cs_data = 1'b1;
    tick(8);
    end_checks("cs_clash_in_addr");

    // Both CS low together: ERR, then a normal address frame
    exp_fe += 1;
    fe_since_rst += 1;
    spi_cs_addr = 1'b0;
    spi_cs_data = 1'b0;
    tick(2);
    send_word(16'hFFFF, 1'b0, '0);
    tick(6);
    spi_cs_addr = 1'b1;
    spi_cs_data = 1'b1;
    tick(8);
    end_checks("both_cs_low");
    addr_frame(16'h0003);
    end_checks("addr_after_err");
    check("addr_literal_0003", addr, 16'h0003);

    // Reset after 8 data bits; the rest of the frame restarts from bit 0
    tx_q.push_back(16'hA5A5);
    tx_q.push_back(16'h5A5A);
    exp_rd += 2;
    exp_fe += 1;
    pat = 16'h3C3C;
    sdo_zero    = 1'b0;
    spi_cs_data = 1'b0;
    tick(2);
    for (int i = W - 1; i >= W - 8; i--) send_bit(pat[i], 1'b1, 16'hA5A5 >> i);
    mon_en = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);
    check_all_zero("mid_frame_reset");
    rst = 1'b0;
    fe_since_rst = 1;
    tick(1);
    mon_en = 1'b1;
    for (int i = W - 9; i >= 0; i--) send_bit(pat[i], 1'b0, 1'b0);
    tick(6);
    spi_cs_data = 1'b1;
    tick(4);
    sdo_zero = 1'b1;
    tick(4);
    end_checks("reset_mid_frame");

    // 300 aborted frames: counter saturates (or stays tied to zero)
    for (int n = 0; n < 300; n++) begin
      spi_cs_addr = 1'b0;
      spi_cs_data = 1'b0;
      tick(4);
      spi_cs_addr = 1'b1;
      spi_cs_data = 1'b1;
      tick(5);
    end
    exp_fe += 300;
    fe_since_rst += 300;
    tick(4);
    end_checks("abort_300");
`ifdef SPI_ERR_CNT_EN
    check("err_cnt_literal_255", err_cnt, 8'd255);
`else
    check("err_cnt_literal_0", err_cnt, 8'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
